target_port: RTL and testbench
==============================

TARGET_PORT -- requirements
Module: target_port

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, serial address length in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, serial data length in bits.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port bus_data  inout  1  shared serial line; driven only while sending read data, else high-Z.
REQ-006 SHALL have port bus_data_in_valid  in  1  qualifies a bit sent by the initiator on bus_data.
REQ-007 SHALL have port bus_mode  in  1  0 = address phase, 1 = data phase.
REQ-008 SHALL have port bus_init_rw  in  1  1 = write, 0 = read.
REQ-009 SHALL have port bus_init_ready  in  1  initiator can accept read bits.
REQ-010 SHALL have port bus_data_out_valid  out  1  target is driving a valid read bit.
REQ-011 SHALL have port target_addr  out  ADDR_WIDTH  deserialised address.
REQ-012 SHALL have port target_addr_valid  out  1  one-cycle pulse, target_addr new.
REQ-013 SHALL have port target_rw  out  1  rw sampled with the last address bit.
REQ-014 SHALL have port target_wdata  out  DATA_WIDTH  deserialised write data.
REQ-015 SHALL have port target_wdata_valid  out  1  one-cycle pulse, target_wdata new.
REQ-016 SHALL have port target_rdata  in  DATA_WIDTH  read data from target core.
REQ-017 SHALL have port target_rdata_valid  in  1  target_rdata valid this cycle.
REQ-018 SHALL have ports target_ack and target_split  in  1 each  core handshake.
REQ-019 SHALL have ports bus_target_ack and bus_target_split  out  1 each  registered copies toward the bus.

Function
REQ-020 SHALL implement FSM states IDLE, ADDR, WDATA, RD_WAIT, RD_SEND.
REQ-021 SHALL shift bits LSB first; a bit is accepted only on an edge where bus_data_in_valid=1 and bus_mode matches the phase (0 in IDLE/ADDR, 1 in WDATA); all other bits ignored.
REQ-022 SHALL hold bit counters across cycles with bus_data_in_valid=0 (gaps allowed, no timeout).
REQ-023 IDLE: accepted address bit -> ADDR with count 1; bus_mode=1 bits in IDLE ignored.
REQ-024 On the edge accepting address bit ADDR_WIDTH, SHALL register target_addr and target_rw=bus_init_rw, pulse target_addr_valid for exactly the following cycle; next state WDATA if rw=1, RD_WAIT if rw=0.
REQ-025 WDATA: on the edge accepting bit DATA_WIDTH, SHALL register target_wdata, pulse target_wdata_valid one cycle, go IDLE.
REQ-026 RD_WAIT: on edge with target_rdata_valid=1, SHALL capture target_rdata into a shift register and go RD_SEND; target_rdata_valid ignored in every other state.
REQ-027 RD_SEND: each edge with bus_init_ready=1 SHALL register the next bit (LSB first) onto bus_data with bus_data_out_valid=1 for that cycle; bus_init_ready=0 -> bus_data_out_valid=0, line high-Z, bit index held.
REQ-028 After the DATA_WIDTH-th bit cycle SHALL release bus_data, drop bus_data_out_valid, return to IDLE; exactly DATA_WIDTH valid bit cycles per read.
REQ-029 bus_data SHALL be high-Z in all states except RD_SEND cycles with bus_data_out_valid=1.
REQ-030 bus_target_ack/bus_target_split SHALL equal target_ack/target_split delayed by one cycle, in every state.
REQ-031 Counters SHALL be sized for ADDR_WIDTH / DATA_WIDTH exactly and clear on every state exit; no wrap into the next transfer.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE, clear counters, shift registers, target_addr, target_wdata, target_rw to 0, all valid/ack/split outputs to 0, bus_data high-Z from the next cycle.
REQ-033 Reset mid-transfer SHALL discard the partial transfer; no valid pulse for it afterward.

Verification
REQ-034 Write: 16 address bits of 16'hA55A (mode 0, rw 1), then 8 bits of 8'h3C (mode 1) -> target_addr=A55A with one pulse, target_rw=1, target_wdata=3C with one pulse.
REQ-035 Read: address 16'h1234 with rw 0, core gives 8'h96 two cycles later, bus_init_ready=1 -> bus_data bits 0,1,1,0,1,0,0,1 over 8 consecutive valid cycles, then high-Z.
REQ-036 Address with 3-cycle gaps in bus_data_in_valid and interleaved mode-1 bits -> target_addr still A55A, exactly one pulse.
REQ-037 Read of 8'h96 with bus_init_ready low for 4 cycles after bit 2 -> same bit sequence, bus_data high-Z and valid 0 during stall.
REQ-038 rst asserted after 7 address bits, then full address 16'h00FF -> only one target_addr_valid pulse, target_addr=00FF.
REQ-039 target_ack=1, target_split=1 for one cycle -> bus_target_ack/bus_target_split high exactly one cycle, one cycle later.

Source files
------------

// File: rtl/target_port.sv
`default_nettype none
// ============================================================================
//  Module   : target_port
//  Purpose  : Serial bus target. Deserialises an LSB-first address (and write
//             data) from a shared single-wire bus, and serialises read data
//             from the target core back onto the same wire with a
//             ready/valid handshake. Core ack/split are registered toward
//             the bus.
//  Revision : 1.0  initial release
// ============================================================================
module target_port #(
  parameter int ADDR_WIDTH = 16,  // serial address length in bits (>= 2)
  parameter int DATA_WIDTH = 8    // serial data length in bits (>= 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire                   bus_data,
  input  logic                  bus_data_in_valid,
  input  logic                  bus_mode,
  input  logic                  bus_init_rw,
  input  logic                  bus_init_ready,
  output logic                  bus_data_out_valid,
  output logic [ADDR_WIDTH-1:0] target_addr,
  output logic                  target_addr_valid,
  output logic                  target_rw,
  output logic [DATA_WIDTH-1:0] target_wdata,
  output logic                  target_wdata_valid,
  input  logic [DATA_WIDTH-1:0] target_rdata,
  input  logic                  target_rdata_valid,
  input  logic                  target_ack,
  input  logic                  target_split,
  output logic                  bus_target_ack,
  output logic                  bus_target_split
);

  // Counter widths: address/write counters only ever hold 0..WIDTH-1, the
  // read index additionally needs the terminal value DATA_WIDTH.
  localparam int ACW = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
  localparam int DCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int RCW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_WDATA   = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_RD_SEND = 3'd4;

  logic [2:0]            r_state;
  logic [2:0]            w_state_next;
  logic [ACW-1:0]        r_addr_cnt;
  logic [DCW-1:0]        r_data_cnt;
  logic [RCW-1:0]        r_rd_idx;
  logic [ADDR_WIDTH-1:0] r_addr_sr;
  logic [DATA_WIDTH-1:0] r_data_sr;
  logic [DATA_WIDTH-1:0] r_rd_sr;
  logic                  r_drive_bit;
  logic                  w_drive_en;

  logic                  w_line;
  logic                  w_addr_bit;
  logic                  w_addr_last;
  logic                  w_data_bit;
  logic                  w_data_last;
  logic                  w_rd_done;
  logic                  w_rd_shift;
  logic [ADDR_WIDTH-1:0] w_addr_shifted;
  logic [DATA_WIDTH-1:0] w_data_shifted;

  // The wire value as seen by this target (only meaningful when the
  // initiator drives it, which is the only time it is sampled).
  assign w_line = bus_data;

  // Address bits are only taken in IDLE/ADDR with mode 0; data bits only in
  // WDATA with mode 1. Everything else on the wire is ignored.
  assign w_addr_bit  = bus_data_in_valid && !bus_mode &&
                       ((r_state == S_IDLE) || (r_state == S_ADDR));
  assign w_addr_last = w_addr_bit && (r_addr_cnt == ACW'(ADDR_WIDTH - 1));
  assign w_data_bit  = bus_data_in_valid && bus_mode && (r_state == S_WDATA);
  assign w_data_last = w_data_bit && (r_data_cnt == DCW'(DATA_WIDTH - 1));

  // The read index reaching DATA_WIDTH means every bit has had its cycle on
  // the wire; the next edge releases the line and returns to IDLE.
  assign w_rd_done  = (r_state == S_RD_SEND) && (r_rd_idx == RCW'(DATA_WIDTH));
  assign w_rd_shift = (r_state == S_RD_SEND) && !w_rd_done && bus_init_ready;

  // LSB-first: each new bit enters at the MSB and earlier bits move down.
  assign w_addr_shifted = {w_line, r_addr_sr[ADDR_WIDTH-1:1]};
  assign w_data_shifted = {w_line, r_data_sr[DATA_WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_ADDR: begin
        if (w_addr_last) begin
          w_state_next = bus_init_rw ? S_WDATA : S_RD_WAIT;
        end else if (w_addr_bit) begin
          w_state_next = S_ADDR;
        end
      end
      S_WDATA: begin
        if (w_data_last) begin
          w_state_next = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (target_rdata_valid) begin
          w_state_next = S_RD_SEND;
        end
      end
      S_RD_SEND: begin
        if (w_rd_done) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode: the wire is driven only while a read bit is valid.
  always_comb begin
    w_drive_en = 1'b0;
    if ((r_state == S_RD_SEND) && bus_data_out_valid) begin
      w_drive_en = 1'b1;
    end
  end

  assign bus_data = w_drive_en ? r_drive_bit : 1'bz;

  // Datapath: shift registers, counters, one-cycle pulses and handshake
  // copies. Counters return to zero whenever their phase is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_cnt         <= '0;
      r_data_cnt         <= '0;
      r_rd_idx           <= '0;
      r_addr_sr          <= '0;
      r_data_sr          <= '0;
      r_rd_sr            <= '0;
      r_drive_bit        <= 1'b0;
      bus_data_out_valid <= 1'b0;
      target_addr        <= '0;
      target_addr_valid  <= 1'b0;
      target_rw          <= 1'b0;
      target_wdata       <= '0;
      target_wdata_valid <= 1'b0;
      bus_target_ack     <= 1'b0;
      bus_target_split   <= 1'b0;
    end else begin
      target_addr_valid  <= 1'b0;
      target_wdata_valid <= 1'b0;
      bus_target_ack     <= target_ack;
      bus_target_split   <= target_split;

      if (w_addr_bit) begin
        r_addr_sr <= w_addr_shifted;
      end
      if (w_addr_last) begin
        r_addr_cnt        <= '0;
        target_addr       <= w_addr_shifted;
        target_rw         <= bus_init_rw;
        target_addr_valid <= 1'b1;
      end else if (w_addr_bit) begin
        r_addr_cnt <= r_addr_cnt + 1'b1;
      end

      if (w_data_bit) begin
        r_data_sr <= w_data_shifted;
      end
      if (w_data_last) begin
        r_data_cnt         <= '0;
        target_wdata       <= w_data_shifted;
        target_wdata_valid <= 1'b1;
      end else if (w_data_bit) begin
        r_data_cnt <= r_data_cnt + 1'b1;
      end

      if ((r_state == S_RD_WAIT) && target_rdata_valid) begin
        r_rd_sr <= target_rdata;
      end else if (w_rd_shift) begin
        r_rd_sr <= r_rd_sr >> 1;
      end

      if (r_state != S_RD_SEND) begin
        r_rd_idx <= '0;
      end else if (w_rd_shift) begin
        r_rd_idx <= r_rd_idx + 1'b1;
      end

      bus_data_out_valid <= w_rd_shift;
      if (w_rd_shift) begin
        r_drive_bit <= r_rd_sr[0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_target_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_target_port
//  Purpose  : Self-checking bench for target_port. Transactions are described
//             at the bus level; expected address/write/read-bit events are
//             queued per transaction and matched against what the DUT emits.
//  Revision : 1.0  initial release
// ============================================================================
module tb_target_port;

  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          tb_en;
  logic          tb_bit;
  wire           bus_data;
  logic          bus_data_in_valid;
  logic          bus_mode;
  logic          bus_init_rw;
  logic          bus_init_ready;
  logic          bus_data_out_valid;
  logic [AW-1:0] target_addr;
  logic          target_addr_valid;
  logic          target_rw;
  logic [DW-1:0] target_wdata;
  logic          target_wdata_valid;
  logic [DW-1:0] target_rdata;
  logic          target_rdata_valid;
  logic          target_ack;
  logic          target_split;
  logic          bus_target_ack;
  logic          bus_target_split;
  logic          line_z;

  assign bus_data = tb_en ? tb_bit : 1'bz;
  assign line_z   = (bus_data === 1'bz);

  target_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus_data           (bus_data),
    .bus_data_in_valid  (bus_data_in_valid),
    .bus_mode           (bus_mode),
    .bus_init_rw        (bus_init_rw),
    .bus_init_ready     (bus_init_ready),
    .bus_data_out_valid (bus_data_out_valid),
    .target_addr        (target_addr),
    .target_addr_valid  (target_addr_valid),
    .target_rw          (target_rw),
    .target_wdata       (target_wdata),
    .target_wdata_valid (target_wdata_valid),
    .target_rdata       (target_rdata),
    .target_rdata_valid (target_rdata_valid),
    .target_ack         (target_ack),
    .target_split       (target_split),
    .bus_target_ack     (bus_target_ack),
    .bus_target_split   (bus_target_split)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gap;
    logic          noise;
    int            stall_at;
    int            stall_len;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic          mon_en = 1'b0;
  logic          rand_ack = 1'b0;
  int            rx_count = 0;
  int            first_bit_cyc = 0;
  int            last_bit_cyc = 0;
  int            n_addr_pulses = 0;
  logic [AW:0]   exp_addr_q[$];
  logic [DW-1:0] exp_wd_q[$];
  logic          exp_bit_q[$];
  logic          ack_q = 1'b0;
  logic          split_q = 1'b0;
  vec_t          vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Handshake copies toward the bus are the core inputs one edge late.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ack_q   <= rst ? 1'b0 : target_ack;
    split_q <= rst ? 1'b0 : target_split;
  end

  // Event monitor: every pulse / read bit must match the next queued event.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ack_delay", 32'(bus_target_ack), 32'(ack_q));
      check("split_delay", 32'(bus_target_split), 32'(split_q));
      if (target_addr_valid) begin
        n_addr_pulses++;
        if (exp_addr_q.size() == 0) begin
          check("unexpected_addr_pulse", 32'(1), 32'(0));
        end else begin
          logic [AW:0] e;
          e = exp_addr_q.pop_front();
          check("addr_value", 32'(target_addr), 32'(e[AW-1:0]));
          check("addr_rw", 32'(target_rw), 32'(e[AW]));
        end
      end
      if (target_wdata_valid) begin
        if (exp_wd_q.size() == 0) begin
          check("unexpected_wdata_pulse", 32'(1), 32'(0));
        end else begin
          logic [DW-1:0] d;
          d = exp_wd_q.pop_front();
          check("wdata_value", 32'(target_wdata), 32'(d));
        end
      end
      if (bus_data_out_valid) begin
        check("line_driven", 32'(line_z), 32'(0));
        if (exp_bit_q.size() == 0) begin
          check("unexpected_read_bit", 32'(1), 32'(0));
        end else begin
          logic b;
          b = exp_bit_q.pop_front();
          check("read_bit", 32'(bus_data), 32'(b));
        end
        if (rx_count == 0) first_bit_cyc = cyc;
        last_bit_cyc = cyc;
        rx_count++;
      end else if (!tb_en) begin
        check("line_released", 32'(line_z), 32'(1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ack) begin
      target_ack   = 1'($urandom_range(0, 1));
      target_split = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int n);
    tb_en = 1'b0;
    bus_data_in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_addr_q_empty"}, 32'(exp_addr_q.size()), 32'(0));
    check({tag, "_wdata_q_empty"}, 32'(exp_wd_q.size()), 32'(0));
    check({tag, "_bit_q_empty"}, 32'(exp_bit_q.size()), 32'(0));
  endtask

  // Address bits LSB first; only the last bit's rw value is meaningful, the
  // others are randomised. Gaps may carry mode-1 bits that must be ignored.
  task automatic send_addr(input logic [AW-1:0] a, input logic rw, input int gap,
                           input logic noise, input logic junk);
    for (int i = 0; i < AW; i++) begin
      tb_en = 1'b1;
      tb_bit = a[i];
      bus_data_in_valid = 1'b1;
      bus_mode = 1'b0;
      bus_init_rw = (i == AW - 1) ? rw : 1'($urandom_range(0, 1));
      target_rdata = DW'($urandom);
      target_rdata_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (i != AW - 1) begin
        for (int g = 0; g < gap; g++) begin
          tb_bit = 1'($urandom_range(0, 1));
          bus_mode = 1'b1;
          bus_data_in_valid = noise && (g % 2 == 0);
          tb_en = bus_data_in_valid;
          tick();
        end
      end
    end
    tb_en = 1'b0;
    bus_data_in_valid = 1'b0;
    target_rdata_valid = 1'b0;
  endtask

  task automatic send_data(input logic [DW-1:0] d, input int gap, input logic noise,
                           input logic junk);
    for (int i = 0; i < DW; i++) begin
      tb_en = 1'b1;
      tb_bit = d[i];
      bus_data_in_valid = 1'b1;
      bus_mode = 1'b1;
      bus_init_rw = 1'($urandom_range(0, 1));
      target_rdata = DW'($urandom);
      target_rdata_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (i != DW - 1) begin
        for (int g = 0; g < gap; g++) begin
          tb_bit = 1'($urandom_range(0, 1));
          bus_mode = 1'b0;
          bus_data_in_valid = noise && (g % 2 == 0);
          tb_en = bus_data_in_valid;
          tick();
        end
      end
    end
    tb_en = 1'b0;
    bus_data_in_valid = 1'b0;
    target_rdata_valid = 1'b0;
  endtask

  task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                           input int gap, input logic noise, input logic junk);
    exp_addr_q.push_back({1'b1, ea});
    exp_wd_q.push_back(ed);
    send_addr(a, 1'b1, gap, noise, junk);
    send_data(d, gap, noise, junk);
    idle(3);
    check_drained("write");
  endtask

  task automatic run_read(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                          input int gap, input logic noise, input int delay,
                          input int stall_at, input int stall_len, input logic rand_ready);
    logic stalled;
    exp_addr_q.push_back({1'b0, ea});
    for (int i = 0; i < DW; i++) exp_bit_q.push_back(ed[i]);
    rx_count = 0;
    bus_init_ready = 1'b1;
    send_addr(a, 1'b0, gap, noise, 1'b1);
    repeat (delay) tick();
    target_rdata = d;
    target_rdata_valid = 1'b1;
    tick();
    target_rdata_valid = 1'b0;
    target_rdata = DW'($urandom);
    stalled = 1'b0;
    for (int c = 0; c < 200 && rx_count < DW; c++) begin
      if (stall_len > 0 && !stalled && rx_count == stall_at) begin
        bus_init_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          @(negedge clk);
          check("stall_valid_low", 32'(bus_data_out_valid), 32'(0));
          check("stall_line_z", 32'(line_z), 32'(1));
        end
        stalled = 1'b1;
      end
      bus_init_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    bus_init_ready = 1'($urandom_range(0, 1));
    idle(3);
    check("read_bit_count", 32'(rx_count), 32'(DW));
    if (!rand_ready && stall_len == 0) begin
      check("read_bits_consecutive", 32'(last_bit_cyc - first_bit_cyc), 32'(DW - 1));
    end
    bus_init_ready = 1'b0;
    check_drained("read");
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_addr", 32'(target_addr), 32'(0));
    check("rst_wdata", 32'(target_wdata), 32'(0));
    check("rst_rw", 32'(target_rw), 32'(0));
    check("rst_addr_valid", 32'(target_addr_valid), 32'(0));
    check("rst_wdata_valid", 32'(target_wdata_valid), 32'(0));
    check("rst_out_valid", 32'(bus_data_out_valid), 32'(0));
    check("rst_ack", 32'(bus_target_ack), 32'(0));
    check("rst_split", 32'(bus_target_split), 32'(0));
    check("rst_line_z", 32'(line_z), 32'(1));
  endtask

  initial begin
    int pulses_before;
    rst = 1'b1;
    tb_en = 1'b0;
    tb_bit = 1'b0;
    bus_data_in_valid = 1'b0;
    bus_mode = 1'b0;
    bus_init_rw = 1'b0;
    bus_init_ready = 1'b0;
    target_rdata = '0;
    target_rdata_valid = 1'b0;
    target_ack = 1'b0;
    target_split = 1'b0;
    repeat (3) tick();
    check_reset_state();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // rw, addr, data, gap, noise, stall_at, stall_len, exp_addr, exp_data
    vecs[0] = '{1'b1, 16'hA55A, 8'h3C, 0, 1'b0, 0, 0, 16'hA55A, 8'h3C};
    vecs[1] = '{1'b0, 16'h1234, 8'h96, 0, 1'b0, 0, 0, 16'h1234, 8'h96};
    vecs[2] = '{1'b1, 16'hA55A, 8'h5A, 3, 1'b1, 0, 0, 16'hA55A, 8'h5A};
    vecs[3] = '{1'b0, 16'hABCD, 8'h96, 0, 1'b0, 2, 4, 16'hABCD, 8'h96};
    vecs[4] = '{1'b1, 16'hFFFF, 8'hFF, 1, 1'b0, 0, 0, 16'hFFFF, 8'hFF};
    vecs[5] = '{1'b1, 16'h0000, 8'h00, 2, 1'b1, 0, 0, 16'h0000, 8'h00};
    vecs[6] = '{1'b0, 16'h8001, 8'h81, 1, 1'b1, 0, 0, 16'h8001, 8'h81};

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].rw) begin
        run_write(vecs[v].addr, vecs[v].data, vecs[v].exp_addr, vecs[v].exp_data,
                  vecs[v].gap, vecs[v].noise, 1'b0);
      end else begin
        run_read(vecs[v].addr, vecs[v].data, vecs[v].exp_addr, vecs[v].exp_data,
                 vecs[v].gap, vecs[v].noise, 1, vecs[v].stall_at, vecs[v].stall_len, 1'b0);
      end
    end

    // Reset after 7 address bits: the partial address must leave no trace.
    begin
      logic [AW-1:0] partial;
      partial = 16'h5A5A;
      pulses_before = n_addr_pulses;
      for (int i = 0; i < 7; i++) begin
        tb_en = 1'b1;
        tb_bit = partial[i];
        bus_data_in_valid = 1'b1;
        bus_mode = 1'b0;
        bus_init_rw = 1'b1;
        tick();
      end
      idle(0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run_write(16'h00FF, 8'h11, 16'h00FF, 8'h11, 0, 1'b0, 1'b0);
      check("reset_mid_pulse_count", 32'(n_addr_pulses - pulses_before), 32'(1));
    end

    // Registered outputs hold non-zero values here; reset must clear them.
    rst = 1'b1;
    tick();
    check_reset_state();
    tick();
    rst = 1'b0;
    tick();

    // Single-cycle ack/split: copies high for exactly the next cycle.
    target_ack = 1'b1;
    target_split = 1'b1;
    tick();
    target_ack = 1'b0;
    target_split = 1'b0;
    @(negedge clk);
    check("ack_one_late", 32'(bus_target_ack), 32'(1));
    check("split_one_late", 32'(bus_target_split), 32'(1));
    tick();
    @(negedge clk);
    check("ack_dropped", 32'(bus_target_ack), 32'(0));
    check("split_dropped", 32'(bus_target_split), 32'(0));
    tick();

    // Randomised transactions against the transaction-level expectations.
    rand_ack = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'($urandom);
      d = DW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        run_write(a, d, a, d, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b1);
      end else begin
        int sl;
        sl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
        run_read(a, d, a, d, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(1, 4)), int'($urandom_range(0, DW - 1)), sl,
                 1'($urandom_range(0, 1)));
      end
    end
    rand_ack = 1'b0;
    idle(3);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
